// File: rtl/cascaded_fifo_chain.sv
// One logical FIFO of SEGMENTS*SEG_DEPTH entries built from cascaded per-segment memories.
// MODE "FIFO" blocks writes when full; MODE "RING" overwrites the oldest entry.
module cascaded_fifo_chain #(
    parameter int WIDTH               = 20,
    parameter int SEG_DEPTH           = 512,
    parameter int SEGMENTS            = 3,
    parameter     MODE                = "FIFO",
    parameter int ALMOST_FULL_OFFSET  = 1,
    parameter int ALMOST_EMPTY_OFFSET = 15
) (
    input  logic                                    clk,
    input  logic                                    rst,
    input  logic                                    PUSH_i,
    input  logic [WIDTH-1:0]                        DI,
    input  logic                                    POP_i,
    output logic [WIDTH-1:0]                        DO,
    output logic                                    DO_VALID_o,
    output logic                                    FULL_o,
    output logic                                    ALMOST_FULL_o,
    output logic                                    EMPTY_o,
    output logic                                    ALMOST_EMPTY_o,
    output logic [$clog2(SEGMENTS*SEG_DEPTH+1)-1:0] LEVEL_o,
    output logic [SEGMENTS-1:0]                     SEG_ACTIVE_o,
    output logic                                    OVERFLOW_o,
    output logic                                    UNDERFLOW_o,
    output logic [15:0]                             DROP_CNT_o
);

    localparam int DEPTH = SEGMENTS * SEG_DEPTH;
    localparam int PW    = $clog2(DEPTH);
    localparam int AW    = $clog2(SEG_DEPTH);
    localparam int SW    = (SEGMENTS > 1) ? $clog2(SEGMENTS) : 1;
    localparam int LW    = $clog2(DEPTH + 1);
    localparam bit RING  = (MODE == "RING");

    logic [PW-1:0]                  wr_ptr, rd_ptr;
    logic [LW-1:0]                  level, level_next;
    logic                           full, empty;
    logic                           push_ok, pop_ok, ring_drop;
    logic [SW-1:0]                  wr_seg, rd_seg, rd_seg_d;
    logic [AW-1:0]                  wr_addr, rd_addr;
    logic                           pop_d;
    logic [SEGMENTS-1:0][WIDTH-1:0] seg_rd;

    // Pointers wrap at DEPTH-1, which need not be a power of two.
    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign wr_seg  = SW'(wr_ptr >> AW);
    assign rd_seg  = SW'(rd_ptr >> AW);
    assign wr_addr = wr_ptr[AW-1:0];
    assign rd_addr = rd_ptr[AW-1:0];

    always_comb begin
        push_ok    = PUSH_i && (!full || RING);
        pop_ok     = POP_i && !empty;
        ring_drop  = RING && PUSH_i && full && !pop_ok;
        level_next = level;
        if (push_ok && !pop_ok && !full)
            level_next = level + LW'(1);
        else if (pop_ok && !push_ok)
            level_next = level - LW'(1);
    end

    // Read-before-write per segment, so a full ring push+pop still returns the old entry.
    for (genvar g = 0; g < SEGMENTS; g++) begin : g_seg
        logic [WIDTH-1:0] mem [SEG_DEPTH];
        logic [WIDTH-1:0] q;
        always_ff @(posedge clk) begin
            if (!rst && push_ok && wr_seg == SW'(g))
                mem[wr_addr] <= DI;
            if (!rst && pop_ok && rd_seg == SW'(g))
                q <= mem[rd_addr];
        end
        assign seg_rd[g] = q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr         <= '0;
            rd_ptr         <= '0;
            level          <= '0;
            empty          <= 1'b1;
            full           <= 1'b0;
            ALMOST_FULL_o  <= 1'b0;
            ALMOST_EMPTY_o <= 1'b1;
            DO             <= '0;
            DO_VALID_o     <= 1'b0;
            pop_d          <= 1'b0;
            rd_seg_d       <= '0;
            OVERFLOW_o     <= 1'b0;
            UNDERFLOW_o    <= 1'b0;
            DROP_CNT_o     <= '0;
        end else begin
            if (push_ok)
                wr_ptr <= ptr_inc(wr_ptr);
            if (pop_ok || ring_drop)
                rd_ptr <= ptr_inc(rd_ptr);
            level          <= level_next;
            empty          <= (level_next == '0);
            full           <= (level_next == LW'(DEPTH));
            ALMOST_FULL_o  <= (int'(level_next) >= DEPTH - ALMOST_FULL_OFFSET);
            ALMOST_EMPTY_o <= (int'(level_next) <= ALMOST_EMPTY_OFFSET);
            // Second stage: select the segment that was read on the previous edge.
            pop_d      <= pop_ok;
            rd_seg_d   <= rd_seg;
            DO_VALID_o <= pop_d;
            if (pop_d)
                DO <= seg_rd[rd_seg_d];
            if (!RING && PUSH_i && full)
                OVERFLOW_o <= 1'b1;
            if (POP_i && empty)
                UNDERFLOW_o <= 1'b1;
            if (ring_drop && DROP_CNT_o != 16'hFFFF)
                DROP_CNT_o <= DROP_CNT_o + 16'd1;
        end
    end

    assign LEVEL_o      = level;
    assign FULL_o       = full;
    assign EMPTY_o      = empty;
    assign SEG_ACTIVE_o = SEGMENTS'(1) << rd_seg;

endmodule

// File: tb/tb_cascaded_fifo_chain.sv
// Directed bench for cascaded_fifo_chain: one FIFO-mode and one RING-mode instance,
// 8-bit data, three segments of four entries (12 entries total).
module tb_cascaded_fifo_chain;

    logic        clk = 1'b0;
    logic        rst;
    logic        f_push, f_pop, r_push, r_pop;
    logic [7:0]  f_di, r_di, f_do, r_do;
    logic        f_dv, f_full, f_af, f_empty, f_ae, f_ovf, f_unf;
    logic        r_dv, r_full, r_af, r_empty, r_ae, r_ovf, r_unf;
    logic [3:0]  f_level, r_level;
    logic [2:0]  f_seg, r_seg;
    logic [15:0] f_drop, r_drop;

    int tests = 0;
    int failures = 0;

    always #5 clk = ~clk;

    cascaded_fifo_chain #(.WIDTH(8), .SEG_DEPTH(4), .SEGMENTS(3), .MODE("FIFO"),
        .ALMOST_FULL_OFFSET(1), .ALMOST_EMPTY_OFFSET(2)) dut_fifo (
        .clk(clk), .rst(rst), .PUSH_i(f_push), .DI(f_di), .POP_i(f_pop),
        .DO(f_do), .DO_VALID_o(f_dv), .FULL_o(f_full), .ALMOST_FULL_o(f_af),
        .EMPTY_o(f_empty), .ALMOST_EMPTY_o(f_ae), .LEVEL_o(f_level),
        .SEG_ACTIVE_o(f_seg), .OVERFLOW_o(f_ovf), .UNDERFLOW_o(f_unf),
        .DROP_CNT_o(f_drop));

    cascaded_fifo_chain #(.WIDTH(8), .SEG_DEPTH(4), .SEGMENTS(3), .MODE("RING"),
        .ALMOST_FULL_OFFSET(1), .ALMOST_EMPTY_OFFSET(2)) dut_ring (
        .clk(clk), .rst(rst), .PUSH_i(r_push), .DI(r_di), .POP_i(r_pop),
        .DO(r_do), .DO_VALID_o(r_dv), .FULL_o(r_full), .ALMOST_FULL_o(r_af),
        .EMPTY_o(r_empty), .ALMOST_EMPTY_o(r_ae), .LEVEL_o(r_level),
        .SEG_ACTIVE_o(r_seg), .OVERFLOW_o(r_ovf), .UNDERFLOW_o(r_unf),
        .DROP_CNT_o(r_drop));

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic apply_fifo(input logic push, input logic [7:0] di, input logic pop);
        f_push = push;
        f_di   = di;
        f_pop  = pop;
    endtask

    task automatic apply_ring(input logic push, input logic [7:0] di, input logic pop);
        r_push = push;
        r_di   = di;
        r_pop  = pop;
    endtask

    task automatic apply_stimulus(input logic push, input logic [7:0] di, input logic pop);
        apply_fifo(push, di, pop);
        apply_ring(push, di, pop);
    endtask

    task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset(input string tag);
        check_output({tag, " f_level"}, 32'(f_level), 0);
        check_output({tag, " f_empty"}, 32'(f_empty), 1);
        check_output({tag, " f_ae"}, 32'(f_ae), 1);
        check_output({tag, " f_full"}, 32'(f_full), 0);
        check_output({tag, " f_af"}, 32'(f_af), 0);
        check_output({tag, " f_do"}, 32'(f_do), 0);
        check_output({tag, " f_dv"}, 32'(f_dv), 0);
        check_output({tag, " f_ovf"}, 32'(f_ovf), 0);
        check_output({tag, " f_unf"}, 32'(f_unf), 0);
        check_output({tag, " f_seg"}, 32'(f_seg), 1);
        check_output({tag, " r_level"}, 32'(r_level), 0);
        check_output({tag, " r_empty"}, 32'(r_empty), 1);
        check_output({tag, " r_do"}, 32'(r_do), 0);
        check_output({tag, " r_dv"}, 32'(r_dv), 0);
        check_output({tag, " r_drop"}, 32'(r_drop), 0);
        check_output({tag, " r_seg"}, 32'(r_seg), 1);
    endtask

    initial begin
        rst = 1'b1;
        apply_stimulus(1'b0, 8'h00, 1'b0);
        tick;
        tick;
        check_reset("por");
        rst = 1'b0;

        // FIFO fill: flags follow the level after every edge.
        for (int i = 1; i <= 12; i++) begin
            apply_fifo(1'b1, 8'(i), 1'b0);
            tick;
            check_output($sformatf("fill level %0d", i), 32'(f_level), i);
            check_output($sformatf("fill ae %0d", i), 32'(f_ae), (i <= 2) ? 1 : 0);
            check_output($sformatf("fill af %0d", i), 32'(f_af), (i >= 11) ? 1 : 0);
            check_output($sformatf("fill full %0d", i), 32'(f_full), (i == 12) ? 1 : 0);
        end
        check_output("fill ovf before", 32'(f_ovf), 0);
        apply_fifo(1'b1, 8'h0D, 1'b0);
        tick;
        check_output("overflow flag", 32'(f_ovf), 1);
        check_output("overflow level", 32'(f_level), 12);

        // FIFO drain with back-to-back pops.
        apply_fifo(1'b0, 8'h00, 1'b1);
        tick;
        for (int i = 1; i <= 12; i++) begin
            int pops;
            f_pop = (i < 12);
            tick;
            pops = (i + 1 > 12) ? 12 : i + 1;
            check_output($sformatf("drain do %0d", i), 32'(f_do), i);
            check_output($sformatf("drain dv %0d", i), 32'(f_dv), 1);
            check_output($sformatf("drain seg %0d", i), 32'(f_seg), 1 << ((pops % 12) / 4));
        end
        check_output("drain empty", 32'(f_empty), 1);
        check_output("drain unf before", 32'(f_unf), 0);
        apply_fifo(1'b0, 8'h00, 1'b1);
        tick;
        check_output("underflow flag", 32'(f_unf), 1);
        apply_fifo(1'b0, 8'h00, 1'b0);
        tick;
        check_output("underflow dv", 32'(f_dv), 0);
        check_output("underflow do hold", 32'(f_do), 8'h0C);

        // Wrap: pointers restart at 0, so 10+6 entries straddle index 11 -> 0.
        for (int i = 0; i < 10; i++) begin
            apply_fifo(1'b1, 8'(8'h20 + i), 1'b0);
            tick;
        end
        apply_fifo(1'b0, 8'h00, 1'b1);
        for (int i = 0; i < 10; i++) tick;
        apply_fifo(1'b0, 8'h00, 1'b0);
        tick;
        check_output("wrap pre do", 32'(f_do), 8'h29);
        check_output("wrap pre level", 32'(f_level), 0);
        for (int i = 0; i < 6; i++) begin
            apply_fifo(1'b1, 8'(8'h30 + i), 1'b0);
            tick;
        end
        check_output("wrap level", 32'(f_level), 6);
        check_output("wrap seg start", 32'(f_seg), 3'b100);
        apply_fifo(1'b0, 8'h00, 1'b1);
        tick;
        for (int i = 0; i < 6; i++) begin
            int pops;
            f_pop = (i < 5);
            tick;
            pops = (i + 2 > 6) ? 6 : i + 2;
            check_output($sformatf("wrap do %0d", i), 32'(f_do), 8'h30 + i);
            check_output($sformatf("wrap seg %0d", i), 32'(f_seg), 1 << (((10 + pops) % 12) / 4));
        end

        // RING: 15 pushes overwrite the three oldest entries.
        for (int i = 1; i <= 15; i++) begin
            apply_ring(1'b1, 8'(i), 1'b0);
            tick;
        end
        check_output("ring level", 32'(r_level), 12);
        check_output("ring drop", 32'(r_drop), 3);
        check_output("ring ovf", 32'(r_ovf), 0);
        check_output("ring full", 32'(r_full), 1);
        apply_ring(1'b0, 8'h00, 1'b1);
        tick;
        for (int i = 0; i < 12; i++) begin
            r_pop = (i < 11);
            tick;
            check_output($sformatf("ring do %0d", i), 32'(r_do), 4 + i);
        end
        check_output("ring drained", 32'(r_empty), 1);
        check_output("ring drop held", 32'(r_drop), 3);

        // Simultaneous push+pop at levels 0, 5 and 12 on both instances.
        rst = 1'b1;
        apply_stimulus(1'b0, 8'h00, 1'b0);
        tick;
        rst = 1'b0;
        apply_stimulus(1'b1, 8'h40, 1'b1);
        tick;
        check_output("pp0 f_level", 32'(f_level), 1);
        check_output("pp0 f_unf", 32'(f_unf), 1);
        check_output("pp0 r_level", 32'(r_level), 1);
        check_output("pp0 r_empty", 32'(r_empty), 0);
        apply_stimulus(1'b0, 8'h00, 1'b0);
        tick;
        check_output("pp0 f_dv", 32'(f_dv), 0);
        for (int i = 1; i <= 4; i++) begin
            apply_stimulus(1'b1, 8'(8'h40 + i), 1'b0);
            tick;
        end
        apply_stimulus(1'b1, 8'h45, 1'b1);
        tick;
        check_output("pp5 f_level", 32'(f_level), 5);
        check_output("pp5 r_level", 32'(r_level), 5);
        apply_stimulus(1'b0, 8'h00, 1'b0);
        tick;
        check_output("pp5 f_do", 32'(f_do), 8'h40);
        check_output("pp5 r_do", 32'(r_do), 8'h40);
        check_output("pp5 f_dv", 32'(f_dv), 1);
        for (int i = 6; i <= 12; i++) begin
            apply_stimulus(1'b1, 8'(8'h40 + i), 1'b0);
            tick;
        end
        check_output("pp12 f_full", 32'(f_full), 1);
        apply_stimulus(1'b1, 8'h4D, 1'b1);
        tick;
        check_output("pp12 f_level", 32'(f_level), 11);
        check_output("pp12 f_ovf", 32'(f_ovf), 1);
        check_output("pp12 f_full", 32'(f_full), 0);
        check_output("pp12 f_af", 32'(f_af), 1);
        check_output("pp12 r_level", 32'(r_level), 12);
        check_output("pp12 r_drop", 32'(r_drop), 0);
        check_output("pp12 r_ovf", 32'(r_ovf), 0);
        apply_stimulus(1'b0, 8'h00, 1'b0);
        tick;
        check_output("pp12 f_do", 32'(f_do), 8'h41);
        check_output("pp12 r_do", 32'(r_do), 8'h41);

        // Drain both to level 7, then reset mid-stream with push and pop asserted.
        apply_stimulus(1'b0, 8'h00, 1'b1);
        for (int i = 0; i < 4; i++) tick;
        apply_fifo(1'b0, 8'h00, 1'b0);
        tick;
        check_output("mid f_level", 32'(f_level), 7);
        check_output("mid r_level", 32'(r_level), 7);
        rst = 1'b1;
        apply_stimulus(1'b1, 8'h77, 1'b1);
        tick;
        check_reset("mid");
        rst = 1'b0;
        apply_stimulus(1'b1, 8'h55, 1'b0);
        tick;
        apply_stimulus(1'b0, 8'h00, 1'b1);
        tick;
        apply_stimulus(1'b0, 8'h00, 1'b0);
        tick;
        check_output("post f_do", 32'(f_do), 8'h55);
        check_output("post f_dv", 32'(f_dv), 1);
        check_output("post r_do", 32'(r_do), 8'h55);
        check_output("post r_empty", 32'(r_empty), 1);

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
